// File: rtl/vram_scanout_pkg.sv
// rtl/vram_scanout_pkg.sv - shared timing constants, types and config check for vram_scanout
package vram_scanout_pkg;

    localparam int H_VISIBLE = 640;
    localparam int H_FRONT   = 16;
    localparam int H_SYNC    = 96;
    localparam int H_BACK    = 48;
    localparam int V_VISIBLE = 480;
    localparam int V_FRONT   = 10;
    localparam int V_SYNC    = 2;
    localparam int V_BACK    = 33;
    localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam int X_OFFSET  = 64;
    localparam int Y_OFFSET  = 112;
    localparam logic [13:0] BASE_ADDR = 14'h0000;

    localparam int SCREEN_W      = 512;
    localparam int SCREEN_H      = 256;
    localparam int WORDS_PER_ROW = SCREEN_W / 16;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic frame;
    } sync_t;

    localparam sync_t SYNC_IDLE = '{hsync: 1'b1, vsync: 1'b1, active: 1'b0, frame: 1'b0};

    // Window must start on a word boundary and sit entirely inside the visible area.
    function automatic bit cfg_ok(input int x_off, input int y_off, input int h_vis,
                                  input int v_vis, input int sw, input int sh);
        return (x_off >= 0) && (y_off >= 0) && (x_off % 16 == 0) && (sw % 16 == 0) &&
               (x_off + sw <= h_vis) && (y_off + sh <= v_vis);
    endfunction

endpackage

// File: rtl/vram_scanout_if.sv
// rtl/vram_scanout_if.sv - VRAM read port between VRAM and the scanout reader
interface vram_scanout_if;
    logic        loaded;
    logic [13:0] raddr;
    logic [15:0] rdata;

    modport master (input loaded, input rdata, output raddr);
    modport slave  (output loaded, output rdata, input raddr);
endinterface

// File: rtl/vram_scanout_video_timing.sv
// rtl/vram_scanout_video_timing.sv - VGA h/v counters with sync/active/frame decode
module video_timing #(
    parameter int H_VISIBLE = vram_scanout_pkg::H_VISIBLE,
    parameter int H_FRONT   = vram_scanout_pkg::H_FRONT,
    parameter int H_SYNC    = vram_scanout_pkg::H_SYNC,
    parameter int H_BACK    = vram_scanout_pkg::H_BACK,
    parameter int V_VISIBLE = vram_scanout_pkg::V_VISIBLE,
    parameter int V_FRONT   = vram_scanout_pkg::V_FRONT,
    parameter int V_SYNC    = vram_scanout_pkg::V_SYNC,
    parameter int V_BACK    = vram_scanout_pkg::V_BACK,
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int HW       = $clog2(H_TOTAL),
    localparam int VW       = $clog2(V_TOTAL)
) (
    input  logic                    clk,
    input  logic                    reset,
    output logic [HW-1:0]           h,
    output logic [VW-1:0]           v,
    output vram_scanout_pkg::sync_t sync
);
    import vram_scanout_pkg::*;

    always_ff @(posedge clk) begin
        if (reset) begin
            h <= '0;
            v <= '0;
        end else if (int'(h) == H_TOTAL - 1) begin
            h <= '0;
            v <= (int'(v) == V_TOTAL - 1) ? '0 : v + 1'b1;
        end else begin
            h <= h + 1'b1;
        end
    end

    always_comb begin
        sync.hsync  = !((int'(h) >= H_VISIBLE + H_FRONT) &&
                        (int'(h) <  H_VISIBLE + H_FRONT + H_SYNC));
        sync.vsync  = !((int'(v) >= V_VISIBLE + V_FRONT) &&
                        (int'(v) <  V_VISIBLE + V_FRONT + V_SYNC));
        sync.active = (int'(h) < H_VISIBLE) && (int'(v) < V_VISIBLE);
        sync.frame  = (h == '0) && (v == '0);
    end

endmodule

// File: rtl/vram_scanout.sv
// rtl/vram_scanout.sv - VGA scanout: fetches screen words from VRAM and serializes them to pixels
module vram_scanout #(
    parameter int H_VISIBLE          = vram_scanout_pkg::H_VISIBLE,
    parameter int H_FRONT            = vram_scanout_pkg::H_FRONT,
    parameter int H_SYNC             = vram_scanout_pkg::H_SYNC,
    parameter int H_BACK             = vram_scanout_pkg::H_BACK,
    parameter int V_VISIBLE          = vram_scanout_pkg::V_VISIBLE,
    parameter int V_FRONT            = vram_scanout_pkg::V_FRONT,
    parameter int V_SYNC             = vram_scanout_pkg::V_SYNC,
    parameter int V_BACK             = vram_scanout_pkg::V_BACK,
    parameter int X_OFFSET           = vram_scanout_pkg::X_OFFSET,
    parameter int Y_OFFSET           = vram_scanout_pkg::Y_OFFSET,
    parameter logic [13:0] BASE_ADDR = vram_scanout_pkg::BASE_ADDR,
    parameter int SCREEN_W           = vram_scanout_pkg::SCREEN_W,
    parameter int SCREEN_H           = vram_scanout_pkg::SCREEN_H,
    localparam int H_TOTAL           = H_VISIBLE + H_FRONT + H_SYNC + H_BACK,
    localparam int V_TOTAL           = V_VISIBLE + V_FRONT + V_SYNC + V_BACK,
    localparam int HW                = $clog2(H_TOTAL),
    localparam int VW                = $clog2(V_TOTAL),
    localparam int WPR               = SCREEN_W / 16
) (
    input  logic           clk,
    input  logic           reset,
    vram_scanout_if.master vram,
    output logic           hsync,
    output logic           vsync,
    output logic           active,
    output logic           pixel,
    output logic           frame
);
    import vram_scanout_pkg::*;

    if (!cfg_ok(X_OFFSET, Y_OFFSET, H_VISIBLE, V_VISIBLE, SCREEN_W, SCREEN_H)) begin : g_bad_cfg
        $error("vram_scanout: window misaligned or outside the visible area");
    end

    logic [HW-1:0] h;
    logic [VW-1:0] v;
    sync_t         sync0, sync1, sync2;
    logic          show;
    int            x0, y0;
    logic          in_win0, fetch0;
    logic          win1, load1;
    logic          pixel_reg;
    logic [15:0]   shifter;

    video_timing #(
        .H_VISIBLE (H_VISIBLE), .H_FRONT (H_FRONT), .H_SYNC (H_SYNC), .H_BACK (H_BACK),
        .V_VISIBLE (V_VISIBLE), .V_FRONT (V_FRONT), .V_SYNC (V_SYNC), .V_BACK (V_BACK)
    ) u_timing (
        .clk   (clk),
        .reset (reset),
        .h     (h),
        .v     (v),
        .sync  (sync0)
    );

    // Stage 0: address is a pure function of the counters so rdata lines up one cycle later.
    always_comb begin
        x0         = int'(h) - X_OFFSET;
        y0         = int'(v) - Y_OFFSET;
        in_win0    = (x0 >= 0) && (x0 < SCREEN_W) && (y0 >= 0) && (y0 < SCREEN_H);
        fetch0     = show && in_win0 && (x0 % 16 == 0);
        vram.raddr = BASE_ADDR;
        if (fetch0) begin
            vram.raddr = BASE_ADDR + 14'(y0 * WPR + x0 / 16);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            show      <= 1'b0;
            sync1     <= SYNC_IDLE;
            sync2     <= SYNC_IDLE;
            win1      <= 1'b0;
            load1     <= 1'b0;
            pixel_reg <= 1'b0;
            shifter   <= '0;
        end else begin
            // loaded only takes effect at a frame boundary so a frame is never half-drawn.
            if (sync0.frame) begin
                show <= vram.loaded;
            end
            sync1 <= sync0;
            sync2 <= sync1;
            win1  <= show && in_win0;
            load1 <= fetch0;
            // Bit 0 is the leftmost pixel, so shift right.
            if (load1) begin
                pixel_reg <= vram.rdata[0];
                shifter   <= {1'b0, vram.rdata[15:1]};
            end else if (win1) begin
                pixel_reg <= shifter[0];
                shifter   <= shifter >> 1;
            end else begin
                pixel_reg <= 1'b0;
            end
        end
    end

    assign hsync  = sync2.hsync;
    assign vsync  = sync2.vsync;
    assign active = sync2.active;
    assign frame  = sync2.frame;
    assign pixel  = pixel_reg;

endmodule

// File: tb/tb_vram_scanout.sv
// tb/tb_vram_scanout.sv - self-checking bench for vram_scanout (scaled and full-size instances)
module tb_vram_scanout;

    localparam int HV = 48, HF = 4, HS = 8, HB = 4;
    localparam int VV = 24, VF = 2, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int XO = 16, YO = 4, SW = 32, SH = 16, WPR = SW / 16;
    localparam logic [13:0] BASE = 14'h3ffe;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
        logic pixel;
        logic frame;
    } out_t;
    localparam out_t IDLE = 5'b11000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rst_q;
    logic hsync, vsync, active, pixel, frame;
    logic f_hsync, f_vsync, f_active, f_pixel, f_frame;
    logic [15:0] mem [16384];

    int checks = 0;
    int errors = 0;

    out_t exp_q[$];
    out_t sb_got, sb_exp;
    logic [13:0] sb_addr;
    int hm, vm;
    logic show_m;

    vram_scanout_if vif ();
    vram_scanout_if vif_f ();

    vram_scanout #(
        .H_VISIBLE (HV), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_VISIBLE (VV), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB),
        .X_OFFSET (XO), .Y_OFFSET (YO), .BASE_ADDR (BASE),
        .SCREEN_W (SW), .SCREEN_H (SH)
    ) dut (
        .clk (clk), .reset (reset), .vram (vif),
        .hsync (hsync), .vsync (vsync), .active (active), .pixel (pixel), .frame (frame)
    );

    vram_scanout dut_full (
        .clk (clk), .reset (reset), .vram (vif_f),
        .hsync (f_hsync), .vsync (f_vsync), .active (f_active), .pixel (f_pixel), .frame (f_frame)
    );

    assign vif_f.loaded = 1'b0;
    assign vif_f.rdata  = 16'h0000;

    always #5 clk = ~clk;

    always @(posedge clk) vif.rdata <= mem[vif.raddr];
    always @(posedge clk) rst_q <= reset;

    function automatic out_t model_out(input int h, input int v, input logic sh);
        out_t o;
        int x, y;
        logic [13:0] a;
        logic [15:0] w;
        x = h - XO;
        y = v - YO;
        o.hsync  = !(h >= HV + HF && h < HV + HF + HS);
        o.vsync  = !(v >= VV + VF && v < VV + VF + VS);
        o.active = (h < HV) && (v < VV);
        o.frame  = (h == 0) && (v == 0);
        o.pixel  = 1'b0;
        if (sh && x >= 0 && x < SW && y >= 0 && y < SH) begin
            a = BASE + 14'(y * WPR + x / 16);
            w = mem[a];
            o.pixel = w[x % 16];
        end
        return o;
    endfunction

    function automatic logic [13:0] model_addr(input int h, input int v, input logic sh);
        int x, y;
        x = h - XO;
        y = v - YO;
        if (sh && x >= 0 && x < SW && y >= 0 && y < SH && x % 16 == 0)
            return BASE + 14'(y * WPR + x / 16);
        return BASE;
    endfunction

    // Expected outputs enter the queue on the counter cycle and leave two cycles later.
    always @(negedge clk) begin
        if (rst_q) begin
            exp_q  = {IDLE, IDLE};
            hm     = 0;
            vm     = 0;
            show_m = 1'b0;
        end
        exp_q.push_back(model_out(hm, vm, show_m));
        sb_exp  = exp_q.pop_front();
        sb_got  = {hsync, vsync, active, pixel, frame};
        sb_addr = model_addr(hm, vm, show_m);
        checks++;
        if (sb_got !== sb_exp) begin
            errors++;
            $display("FAIL sb_pins at counter h=%0d v=%0d: got %b expected %b", hm, vm, sb_got, sb_exp);
        end
        checks++;
        if (vif.raddr !== sb_addr) begin
            errors++;
            $display("FAIL sb_raddr at h=%0d v=%0d: got %h expected %h", hm, vm, vif.raddr, sb_addr);
        end
        if (hm == 0 && vm == 0) show_m = vif.loaded;
        if (hm == HT - 1) begin
            hm = 0;
            vm = (vm == VT - 1) ? 0 : vm + 1;
        end else begin
            hm = hm + 1;
        end
    end

    task automatic clear_mem();
        foreach (mem[i]) mem[i] = 16'h0000;
    endtask

    task automatic do_reset(input int n);
        @(posedge clk);
        #1 reset = 1'b1;
        repeat (n) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        int fall, width, fr;
        fall = -1; width = 0; fr = -1;
        vif.loaded = 1'b0;
        clear_mem();
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({f_hsync, f_vsync, f_active, f_pixel, f_frame} !== 5'b11000) begin
            errors++;
            $display("FAIL reset_pins: got %b expected 11000", {f_hsync, f_vsync, f_active, f_pixel, f_frame});
        end
        checks++;
        if (vif_f.raddr !== 14'h0000) begin
            errors++;
            $display("FAIL reset_raddr: got %h expected 0000", vif_f.raddr);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (f_frame && fr < 0) fr = c;
            if (!f_hsync && fall < 0) fall = c;
            if (fall >= 0 && c < fall + 200 && !f_hsync) width++;
        end
        checks++;
        if (fr !== 2) begin
            errors++;
            $display("FAIL first_frame_cycle: got %0d expected 2", fr);
        end
        checks++;
        if (fall !== 658) begin
            errors++;
            $display("FAIL hsync_first_fall: got %0d expected 658", fall);
        end
        checks++;
        if (width !== 96) begin
            errors++;
            $display("FAIL hsync_width: got %0d expected 96", width);
        end
    endtask

    task automatic test_timing();
        int vs_low, act;
        vs_low = 0; act = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            if (!vsync) vs_low++;
            if (active) act++;
        end
        checks++;
        if (vs_low !== 2 * VS * HT) begin
            errors++;
            $display("FAIL vsync_low_count: got %0d expected %0d", vs_low, 2 * VS * HT);
        end
        checks++;
        if (act !== 2 * HV * VV) begin
            errors++;
            $display("FAIL active_count: got %0d expected %0d", act, 2 * HV * VV);
        end
    endtask

    task automatic test_word_bits();
        int n, first, second;
        n = 0; first = -1; second = -1;
        clear_mem();
        mem[BASE] = 16'h8001;
        vif.loaded = 1'b1;
        do_reset(2);
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (pixel === 1'b1) begin
                n++;
                if (n == 1) first = c;
                if (n == 2) second = c;
            end
        end
        checks++;
        if (n !== 2) begin
            errors++;
            $display("FAIL word_bits_count: got %0d expected 2", n);
        end
        checks++;
        if (first !== YO * HT + XO + 2 || second !== YO * HT + XO + 15 + 2) begin
            errors++;
            $display("FAIL word_bits_pos: got %0d,%0d expected %0d,%0d", first, second,
                     YO * HT + XO + 2, YO * HT + XO + 17);
        end
    endtask

    task automatic test_late_loaded();
        int p0, p1;
        p0 = 0; p1 = 0;
        vif.loaded = 1'b0;
        do_reset(2);
        for (int c = 0; c < 2 * FRAME; c++) begin
            @(negedge clk);
            if (c == (YO + 5) * HT) vif.loaded = 1'b1;
            if (pixel === 1'b1) begin
                if (c < FRAME) p0++;
                else p1++;
            end
        end
        checks++;
        if (p0 !== 0) begin
            errors++;
            $display("FAIL late_loaded_frame0: got %0d pixels expected 0", p0);
        end
        checks++;
        if (p1 !== 2) begin
            errors++;
            $display("FAIL late_loaded_frame1: got %0d pixels expected 2", p1);
        end
    endtask

    task automatic test_single_pixel();
        int n, pos;
        logic [13:0] seen;
        n = 0; pos = -1; seen = 14'h0;
        clear_mem();
        mem[14'(BASE + 3 * WPR + 1)] = 16'h0001;
        vif.loaded = 1'b1;
        do_reset(2);
        for (int c = 0; c < FRAME; c++) begin
            @(negedge clk);
            if (c == (YO + 3) * HT + XO + 16) seen = vif.raddr;
            if (pixel === 1'b1) begin
                n++;
                pos = c;
            end
        end
        checks++;
        if (n !== 1 || pos !== (YO + 3) * HT + XO + 16 + 2) begin
            errors++;
            $display("FAIL single_pixel: got %0d at %0d expected 1 at %0d", n, pos,
                     (YO + 3) * HT + XO + 18);
        end
        checks++;
        if (seen !== 14'h0005) begin
            errors++;
            $display("FAIL single_pixel_raddr: got %h expected 0005", seen);
        end
    endtask

    task automatic test_reset_mid();
        int fr, fall;
        fr = -1; fall = -1;
        repeat (10 * HT + 30) @(negedge clk);
        do_reset(1);
        for (int c = 0; c < HT; c++) begin
            @(negedge clk);
            if (frame && fr < 0) fr = c;
            if (!hsync && fall < 0) fall = c;
        end
        checks++;
        if (fr !== 2) begin
            errors++;
            $display("FAIL mid_reset_frame: got %0d expected 2", fr);
        end
        checks++;
        if (fall !== HV + HF + 2) begin
            errors++;
            $display("FAIL mid_reset_hsync: got %0d expected %0d", fall, HV + HF + 2);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vif.loaded = 1'b0;
        test_reset();
        test_timing();
        test_word_bits();
        test_late_loaded();
        test_single_pixel();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
